// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data_mem between pat core and host loader, core priority with host starvation bound
module dmem_arbiter #(
    parameter int d_adr_width = 8,
    parameter int d_width     = 8,
    parameter int hold_max    = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   core_req_i,
    input  logic                   core_we_i,
    input  logic [d_adr_width-1:0] core_adr_i,
    input  logic [d_width-1:0]     core_wdata_i,
    output logic                   core_gnt_o,
    output logic                   core_rvalid_o,
    output logic [d_width-1:0]     core_rdata_o,
    input  logic                   host_req_i,
    input  logic                   host_we_i,
    input  logic [d_adr_width-1:0] host_adr_i,
    input  logic [d_width-1:0]     host_wdata_i,
    output logic                   host_gnt_o,
    output logic                   host_rvalid_o,
    output logic [d_width-1:0]     host_rdata_o,
    output logic [d_adr_width-1:0] mem_read_adr_o,
    output logic [d_adr_width-1:0] mem_write_adr_o,
    output logic                   mem_write_o,
    output logic [d_width-1:0]     mem_data_in_o,
    input  logic [d_width-1:0]     mem_data_out_i
);
    typedef enum logic [1:0] {IDLE, G_CORE, G_HOST} state_t;
    localparam logic [3:0] hold_lim = 4'(hold_max);
    state_t                 state_q, state_d;
    logic [3:0]             starve_q, starve_d;
    logic [d_adr_width-1:0] adr_q, adr_d;
    logic [d_width-1:0]     wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   core_rvalid_q, core_rvalid_d;
    logic                   host_rvalid_q, host_rvalid_d;
    logic [d_width-1:0]     core_rdata_q, core_rdata_d;
    logic [d_width-1:0]     host_rdata_q, host_rdata_d;

    // arbitration, port register next values and read-data capture of the previous grant
    always_comb begin
        state_d       = IDLE;
        starve_d      = '0;
        adr_d         = adr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        core_rvalid_d = (state_q == G_CORE) && !we_q;
        host_rvalid_d = (state_q == G_HOST) && !we_q;
        core_rdata_d  = core_rvalid_d ? mem_data_out_i : core_rdata_q;
        host_rdata_d  = host_rvalid_d ? mem_data_out_i : host_rdata_q;
        if (core_req_i && host_req_i && starve_q < hold_lim) begin
            state_d  = G_CORE;
            starve_d = starve_q + 4'd1;
        end else if (host_req_i) begin
            state_d = G_HOST;
        end else if (core_req_i) begin
            state_d = G_CORE;
        end
        if (state_d == G_CORE) begin
            adr_d   = core_adr_i;
            wdata_d = core_wdata_i;
            we_d    = core_we_i;
        end else if (state_d == G_HOST) begin
            adr_d   = host_adr_i;
            wdata_d = host_wdata_i;
            we_d    = host_we_i;
        end
    end

    // state and port registers; reset drops rvalid of a grant in flight
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            adr_q         <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            adr_q         <= adr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign core_gnt_o      = state_q == G_CORE;
    assign host_gnt_o      = state_q == G_HOST;
    assign core_rvalid_o   = core_rvalid_q;
    assign host_rvalid_o   = host_rvalid_q;
    assign core_rdata_o    = core_rdata_q;
    assign host_rdata_o    = host_rdata_q;
    assign mem_read_adr_o  = adr_q;
    assign mem_write_adr_o = adr_q;
    assign mem_write_o     = we_q;
    assign mem_data_in_o   = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with read-data scoreboard for dmem_arbiter
module tb_dmem_arbiter;
    logic       clk, reset_n;
    logic       core_req, core_we, host_req, host_we;
    logic [7:0] core_adr, core_wdata, host_adr, host_wdata;
    logic       core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [7:0] core_rdata, host_rdata;
    logic [7:0] mem_read_adr, mem_write_adr, mem_data_in, mem_data_out;
    logic       mem_write;
    logic [7:0] mem [256];
    logic [7:0] core_q[$], host_q[$];
    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.d_adr_width(8), .d_width(8), .hold_max(4)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_adr_i(core_adr), .core_wdata_i(core_wdata),
        .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .host_req_i(host_req), .host_we_i(host_we), .host_adr_i(host_adr), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
        .mem_read_adr_o(mem_read_adr), .mem_write_adr_o(mem_write_adr), .mem_write_o(mem_write),
        .mem_data_in_o(mem_data_in), .mem_data_out_i(mem_data_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // data_mem model: synchronous write, combinational read
    assign mem_data_out = mem[mem_read_adr];
    always @(posedge clk) if (mem_write) mem[mem_write_adr] <= mem_data_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: pops expected read data on rvalid, checks grant/strobe invariants
    always @(negedge clk) begin
        check("gnt_exclusive", {31'd0, core_gnt & host_gnt}, 0);
        check("write_needs_gnt", {31'd0, mem_write & ~(core_gnt | host_gnt)}, 0);
        if (core_rvalid) begin
            if (core_q.size() == 0) check("core_rvalid_unexpected", 1, 0);
            else check("core_rdata", {24'd0, core_rdata}, {24'd0, core_q.pop_front()});
        end
        if (host_rvalid) begin
            if (host_q.size() == 0) check("host_rvalid_unexpected", 1, 0);
            else check("host_rdata", {24'd0, host_rdata}, {24'd0, host_q.pop_front()});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h12] = 8'hA5;
        reset_n = 0;
        core_req = 1; core_we = 0; core_adr = 8'h12; core_wdata = 8'h00;
        host_req = 1; host_we = 0; host_adr = 8'h40; host_wdata = 8'h00;
        // T1 reset with both requests held
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", {30'd0, core_gnt, host_gnt}, 0);
            check("rst_rvalid", {30'd0, core_rvalid, host_rvalid}, 0);
            check("rst_mem_write", {31'd0, mem_write}, 0);
        end
        check("rst_rdata", {16'd0, core_rdata, host_rdata}, 0);
        core_req = 0; host_req = 0; reset_n = 1;
        tick();
        // T2 core read
        core_req = 1; core_we = 0; core_adr = 8'h12;
        tick();
        check("t2_core_gnt", {30'd0, core_gnt, host_gnt}, 2);
        check("t2_read_adr", {24'd0, mem_read_adr}, 32'h12);
        core_q.push_back(8'hA5);
        core_req = 0;
        tick();
        check("t2_core_rvalid", {31'd0, core_rvalid}, 1);
        check("t2_core_gnt_drop", {31'd0, core_gnt}, 0);
        tick();
        // T3 host write then read back-to-back
        host_req = 1; host_we = 1; host_adr = 8'h40; host_wdata = 8'h3C;
        tick();
        check("t3_host_gnt", {30'd0, core_gnt, host_gnt}, 1);
        check("t3_mem_write", {31'd0, mem_write}, 1);
        check("t3_write_adr", {24'd0, mem_write_adr}, 32'h40);
        check("t3_data_in", {24'd0, mem_data_in}, 32'h3C);
        host_we = 0; host_wdata = 8'h00;
        tick();
        check("t3_read_gnt", {31'd0, host_gnt}, 1);
        check("t3_write_one_cycle", {31'd0, mem_write}, 0);
        check("t3_read_adr", {24'd0, mem_read_adr}, 32'h40);
        host_q.push_back(8'h3C);
        host_req = 0;
        tick();
        tick();
        // T4/T5 starvation bound with host write... held as read so the slot is observable
        core_req = 1; core_we = 0; core_adr = 8'h12;
        host_req = 1; host_we = 0; host_adr = 8'h40;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i % 5 == 4) begin
                check("t4_host_slot", {30'd0, core_gnt, host_gnt}, 1);
                check("t4_host_adr", {24'd0, mem_read_adr}, 32'h40);
                host_q.push_back(8'h3C);
            end else begin
                check("t4_core_slot", {30'd0, core_gnt, host_gnt}, 2);
                check("t4_core_adr", {24'd0, mem_read_adr}, 32'h12);
                check("t5_no_write", {31'd0, mem_write}, 0);
                core_q.push_back(8'hA5);
            end
        end
        core_req = 0; host_req = 0;
        repeat (3) tick();
        // T6 reset at the edge ending a core read grant, request held through reset
        core_req = 1; core_we = 0; core_adr = 8'h12;
        tick();
        check("t6_core_gnt", {31'd0, core_gnt}, 1);
        reset_n = 0;
        tick();
        check("t6_rvalid_suppressed", {31'd0, core_rvalid}, 0);
        check("t6_gnt_cleared", {30'd0, core_gnt, host_gnt}, 0);
        check("t6_mem_write", {31'd0, mem_write}, 0);
        tick();
        reset_n = 1;
        tick();
        check("t6_rearb_gnt", {30'd0, core_gnt, host_gnt}, 2);
        core_q.push_back(8'hA5);
        core_req = 0;
        repeat (3) tick();
        check("core_q_drained", core_q.size(), 0);
        check("host_q_drained", host_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
